ctrl_pipe: RTL

- Pipelined control unit for the 5-stage RV32I(+M multiply) core.
- Decodes the ID-stage instruction into a packed control bundle and carries it through the ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards, stalls for multi-cycle multiplies, and applies branch/jump flushes.
- Replaces the purely combinational decoder. The datapath consumes the per-stage bundles directly.

---
 rtl/ctrl_pipe.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipelined control unit for the 5-stage RV32I(+M multiply) core.
// Decodes the ID instruction into an 11-bit control bundle and carries it
// through the ID/EX, EX/MEM and MEM/WB registers. It also generates the
// load-use stall, the multi-cycle multiply hold and the branch/jump flush.
//
// Bundle layout [10:0]:
//   [10] alu_src [9] mem2reg [8] reg_write [7] mem_read [6] mem_write
//   [5:4] aluop  [3] branch  [2] jalr_mode [1] jal_mode [0] mul_op
// An all-zero bundle is a bubble.
//
// Pipeline control contract: stall_pc/stall_ifid mean "the front end must
// present the same ID instruction again next cycle". flush_ifid means "the
// front end must replace the IF/ID contents with a bubble". There is no
// ready signal back from the datapath: the stage registers always update on
// every clock edge, with hold, bubble or advance selected here.

module ctrl_pipe #(
   parameter int REG_ADDR_W  = 5,
   parameter int MUL_LATENCY = 4,
   parameter int CNT_W       = $clog2(MUL_LATENCY + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           id_inst,
   input  logic                  id_valid,
   input  logic                  flush,
   output logic [10:0]           ex_ctrl,
   output logic [10:0]           mem_ctrl,
   output logic [10:0]           wb_ctrl,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic [REG_ADDR_W-1:0] mem_rd,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic                  stall_pc,
   output logic                  stall_ifid,
   output logic                  flush_ifid,
   output logic                  mul_busy
);

   // RV32I major opcodes
   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_LOAD_FP = 7'b0000111;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;

   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   // A latency of 1 means the multiplier fits in the normal EX slot.
   localparam bit MUL_STALL_EN = (MUL_LATENCY > 1);

   typedef struct packed {
      logic       alu_src;
      logic       mem2reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic [1:0] aluop;
      logic       branch;
      logic       jalr_mode;
      logic       jal_mode;
      logic       mul_op;
   } ctrl_t;

   typedef enum logic {
      IDLE     = 1'b0,
      MUL_HOLD = 1'b1
   } state_t;

   // ------------------------------------------------------------------
   // ID-stage field extraction
   // ------------------------------------------------------------------
   logic [6:0]            id_opcode;
   logic [6:0]            id_funct7;
   logic [REG_ADDR_W-1:0] id_rd;
   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   // funct3 selects the operation inside the datapath; the control bundle
   // does not depend on it.
   logic                  unused_funct3;

   assign id_opcode     = id_inst[6:0];
   assign id_funct7     = id_inst[31:25];
   assign id_rd         = REG_ADDR_W'(id_inst[11:7]);
   assign id_rs1        = REG_ADDR_W'(id_inst[19:15]);
   assign id_rs2        = REG_ADDR_W'(id_inst[24:20]);
   assign unused_funct3 = ^id_inst[14:12];

   logic is_load, is_load_fp, is_store, is_op_imm, is_op;
   logic is_lui, is_auipc, is_branch, is_jalr, is_jal;

   assign is_load    = (id_opcode == OPC_LOAD);
   assign is_load_fp = (id_opcode == OPC_LOAD_FP);
   assign is_store   = (id_opcode == OPC_STORE);
   assign is_op_imm  = (id_opcode == OPC_OP_IMM);
   assign is_op      = (id_opcode == OPC_OP);
   assign is_lui     = (id_opcode == OPC_LUI);
   assign is_auipc   = (id_opcode == OPC_AUIPC);
   assign is_branch  = (id_opcode == OPC_BRANCH);
   assign is_jalr    = (id_opcode == OPC_JALR);
   assign is_jal     = (id_opcode == OPC_JAL);

   // ------------------------------------------------------------------
   // Pipeline state
   // ------------------------------------------------------------------
   ctrl_t                 id_ctrl;
   ctrl_t                 ex_q, mem_q, wb_q;
   logic [REG_ADDR_W-1:0] ex_rd_q, mem_rd_q, wb_rd_q;

   state_t                state_q, state_nxt;
   logic [CNT_W-1:0]      cnt_q, cnt_nxt;

   logic                  rs1_used, rs2_used;
   logic                  load_use;
   logic                  mul_start;   // fresh mul in EX, hold begins this cycle
   logic                  mul_hold;    // any cycle in which a mul owns EX beyond its slot
   logic                  mul_last;    // final hold cycle: the mul leaves EX on this edge

   // Decode the ID instruction into a control bundle; invalid ID is a bubble.
   always_comb begin
      id_ctrl = '0;
      if (id_valid) begin
         id_ctrl.alu_src   = is_load | is_store | is_op_imm | is_jalr | is_lui;
         id_ctrl.mem2reg   = is_load | is_load_fp;
         id_ctrl.reg_write = (is_load | is_op_imm | is_op | is_jal | is_jalr |
                              is_lui | is_auipc) & (id_rd != '0);
         id_ctrl.mem_read  = is_load;
         id_ctrl.mem_write = is_store;
         if (is_branch)
            id_ctrl.aluop = 2'b01;
         else if (is_lui | is_auipc | is_jal)
            id_ctrl.aluop = 2'b11;
         else if (is_op | is_op_imm)
            id_ctrl.aluop = 2'b10;
         else
            id_ctrl.aluop = 2'b00;
         id_ctrl.branch    = is_branch;
         id_ctrl.jalr_mode = is_jalr;
         id_ctrl.jal_mode  = is_jal;
         id_ctrl.mul_op    = is_op & (id_funct7 == FUNCT7_MULDIV);
      end
   end

   // Load-use hazard: the load in EX writes a register the ID instruction reads.
   always_comb begin
      rs1_used = ~(is_lui | is_auipc | is_jal);
      rs2_used = is_op | is_store | is_branch;
      load_use = id_valid & ex_q.mem_read & (ex_rd_q != '0) &
                 ((rs1_used & (ex_rd_q == id_rs1)) |
                  (rs2_used & (ex_rd_q == id_rs2)));
   end

   // Multiply-hold FSM state and counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
      end
   end

   // Multiply-hold next state, counter and front-end control outputs.
   // The mul occupies EX for the IDLE cycle in which it is first seen plus
   // MUL_LATENCY-1 MUL_HOLD cycles. It leaves EX on the edge that returns the
   // FSM to IDLE, so a returning IDLE never sees the same mul again. During
   // that last hold cycle the front end is still stalled and ID/EX takes a
   // bubble, so the held ID instruction enters EX one cycle later.
   always_comb begin
      state_nxt  = state_q;
      cnt_nxt    = cnt_q;
      mul_start  = 1'b0;
      mul_last   = 1'b0;
      mul_hold   = 1'b0;
      mul_busy   = 1'b0;
      stall_pc   = 1'b0;
      stall_ifid = 1'b0;
      flush_ifid = 1'b0;

      case (state_q)
         IDLE: begin
            if (MUL_STALL_EN && ex_q.mul_op) begin
               mul_start = 1'b1;
               state_nxt = MUL_HOLD;
               cnt_nxt   = CNT_W'(MUL_LATENCY - 1);
            end
         end
         MUL_HOLD: begin
            cnt_nxt = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               mul_last  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase

      mul_hold = mul_start | (state_q == MUL_HOLD);

      if (!reset) begin
         mul_busy   = (state_q == MUL_HOLD);
         stall_pc   = mul_hold | (load_use & ~flush);
         stall_ifid = mul_hold | (load_use & ~flush);
         flush_ifid = flush & ~mul_hold;
      end
   end

   // Stage registers: hold/bubble/advance selected by the mul hold, flush and load-use.
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q     <= '0;
         mem_q    <= '0;
         wb_q     <= '0;
         ex_rd_q  <= '0;
         mem_rd_q <= '0;
         wb_rd_q  <= '0;
      end else begin
         wb_q    <= mem_q;
         wb_rd_q <= mem_rd_q;
         if (mul_hold && !mul_last) begin
            // mul stays in EX; nothing retires from EX this cycle
            mem_q    <= '0;
            mem_rd_q <= '0;
         end else if (mul_last) begin
            mem_q    <= ex_q;
            mem_rd_q <= ex_rd_q;
            ex_q     <= '0;
            ex_rd_q  <= '0;
         end else begin
            mem_q    <= ex_q;
            mem_rd_q <= ex_rd_q;
            if (flush || load_use || !id_valid) begin
               ex_q    <= '0;
               ex_rd_q <= '0;
            end else begin
               ex_q    <= id_ctrl;
               ex_rd_q <= id_rd;
            end
         end
      end
   end

   assign ex_ctrl  = ex_q;
   assign mem_ctrl = mem_q;
   assign wb_ctrl  = wb_q;
   assign ex_rd    = ex_rd_q;
   assign mem_rd   = mem_rd_q;
   assign wb_rd    = wb_rd_q;

endmodule
